// File: rtl/axis_addr_split_pkg.sv
// Shared types and derived-constant helpers for the AXI address splitter.
// Contents:
//   state_t      - splitter FSM states (IDLE, CALC, ADDR)
//   beat_bytes   - bytes per AXI beat for a given stream width and width ratio
//   beat_shift   - log2 of beat_bytes
//   bound_beats  - beats contained in one boundary window
//   rem_width    - width of the remaining-beats counter
//   out_width    - width of the outstanding-burst counter
package axis_addr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_ADDR = 2'd2
  } state_t;

  function automatic int unsigned beat_bytes(input int unsigned dw, input int unsigned ratio);
    return (dw * ratio) / 8;
  endfunction

  function automatic int unsigned beat_shift(input int unsigned dw, input int unsigned ratio);
    return $clog2(beat_bytes(dw, ratio));
  endfunction

  function automatic int unsigned bound_beats(input int unsigned boundary,
                                              input int unsigned dw,
                                              input int unsigned ratio);
    return boundary / beat_bytes(dw, ratio);
  endfunction

  // One extra bit so the beat count of a maximum-length transfer still fits.
  function automatic int unsigned rem_width(input int unsigned dw, input int unsigned ratio);
    return dw - $clog2(ratio) + 1;
  endfunction

  function automatic int unsigned out_width(input int unsigned max_out);
    return $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/axis_addr_split_if.sv
// Config + AXI address-channel bundle for axis_addr_split.
// Signals:
//   cfg_address/cfg_length/cfg_val/cfg_rdy  - config transfer handshake
//   axi_aaddr/axi_alen/axi_avalid/axi_aready - AXI AR/AW address channel
//   axi_done                                 - one-cycle completion pulse per burst
//   outstanding                              - bursts issued but not completed
// Modports: master = the splitter, slave = config source / AXI side.
interface axis_addr_split_if
  import axis_addr_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH      = 32,
  parameter int unsigned AXI_LEN_WIDTH   = 8,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) ();

  localparam int unsigned OUT_W = out_width(MAX_OUTSTANDING);

  logic [CFG_DWIDTH-1:0]     cfg_address;
  logic [CFG_DWIDTH-1:0]     cfg_length;
  logic                      cfg_val;
  logic                      cfg_rdy;
  logic                      axi_aready;
  logic [AXI_ADDR_WIDTH-1:0] axi_aaddr;
  logic [AXI_LEN_WIDTH-1:0]  axi_alen;
  logic                      axi_avalid;
  logic                      axi_done;
  logic [OUT_W-1:0]          outstanding;

  modport master (
    input  cfg_address, cfg_length, cfg_val, axi_aready, axi_done,
    output cfg_rdy, axi_aaddr, axi_alen, axi_avalid, outstanding
  );

  modport slave (
    output cfg_address, cfg_length, cfg_val, axi_aready, axi_done,
    input  cfg_rdy, axi_aaddr, axi_alen, axi_avalid, outstanding
  );

endinterface

// File: rtl/axis_addr_split_burst_calc.sv
// Combinational burst sizer: beats = min(remaining, MAX_BURST, beats left
// before the next BOUNDARY multiple).
// Ports:
//   i_remaining - beats still to issue for the current transfer
//   i_beat_idx  - beat index of the burst start within its boundary window
//   o_beats     - beats for the next burst
module axis_addr_burst_calc #(
  parameter int unsigned REM_W       = 29,
  parameter int unsigned IDX_W       = 6,
  parameter int unsigned MAX_BURST   = 256,
  parameter int unsigned BOUND_BEATS = 64
) (
  input  logic [REM_W-1:0] i_remaining,
  input  logic [IDX_W-1:0] i_beat_idx,
  output logic [REM_W-1:0] o_beats
);

  logic [REM_W-1:0] w_to_bound;
  logic [REM_W-1:0] w_lim;

  assign w_to_bound = REM_W'(BOUND_BEATS) - REM_W'(i_beat_idx);

  always_comb begin
    w_lim = i_remaining;
    if (w_lim > REM_W'(MAX_BURST)) w_lim = REM_W'(MAX_BURST);
    o_beats = w_lim;
    if (o_beats > w_to_bound) o_beats = w_to_bound;
  end

endmodule

// File: rtl/axis_addr_split.sv
// Splits one {byte address, word length} config transfer into AXI address
// bursts limited by MAX_BURST, the BOUNDARY window and a credit limit of
// MAX_OUTSTANDING bursts awaiting completion.
// Ports:
//   clk  - clock
//   rst  - synchronous active-low reset
//   bus  - axis_addr_split_if.master (config in, AXI address channel out,
//          completion pulse in, outstanding count out)
module axis_addr_split
  import axis_addr_pkg::*;
#(
  parameter int unsigned CFG_DWIDTH      = 32,
  parameter int unsigned WIDTH_RATIO     = 16,
  parameter int unsigned CONVERT_SHIFT   = $clog2(WIDTH_RATIO),
  parameter int unsigned AXI_LEN_WIDTH   = 8,
  parameter int unsigned AXI_ADDR_WIDTH  = 32,
  parameter int unsigned MAX_BURST       = 256,
  parameter int unsigned BOUNDARY        = 4096,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input logic              clk,
  input logic              rst,
  axis_addr_split_if.master bus
);

  localparam int unsigned BEAT_BYTES  = beat_bytes(CFG_DWIDTH, WIDTH_RATIO);
  localparam int unsigned BEAT_SHIFT  = beat_shift(CFG_DWIDTH, WIDTH_RATIO);
  localparam int unsigned BOUND_BEATS = bound_beats(BOUNDARY, CFG_DWIDTH, WIDTH_RATIO);
  localparam int unsigned BOUND_SHIFT = $clog2(BOUNDARY);
  localparam int unsigned REM_W       = CFG_DWIDTH - CONVERT_SHIFT + 1;
  localparam int unsigned OUT_W       = out_width(MAX_OUTSTANDING);
  localparam int unsigned SUM_W       = CFG_DWIDTH + 1;
  localparam int unsigned AW          = AXI_ADDR_WIDTH;
  localparam int unsigned LW          = AXI_LEN_WIDTH;

  state_t            r_state;
  state_t            w_next;
  logic [AW-1:0]     r_addr;
  logic [REM_W-1:0]  r_remaining;
  logic [REM_W-1:0]  r_beats;
  logic [AW-1:0]     r_aaddr;
  logic [LW-1:0]     r_alen;
  logic [OUT_W-1:0]  r_outstanding;

  logic [SUM_W-1:0]  w_len_round;
  logic [REM_W-1:0]  w_total;
  logic [AW-1:0]     w_cfg_addr;
  logic [REM_W-1:0]  w_beats;
  logic              w_addr_hs;
  logic              w_done_eff;
  logic              w_credit;
  logic              w_last;
  logic              w_cfg_rdy;
  logic              w_avalid;

  // Round up to whole beats; computed one bit wider so max length cannot wrap.
  assign w_len_round = {1'b0, bus.cfg_length} + SUM_W'(WIDTH_RATIO - 1);
  assign w_total     = REM_W'(w_len_round >> CONVERT_SHIFT);
  assign w_cfg_addr  = AW'(bus.cfg_address) & ~AW'(BEAT_BYTES - 1);

  axis_addr_burst_calc #(
    .REM_W       (REM_W),
    .IDX_W       (BOUND_SHIFT - BEAT_SHIFT),
    .MAX_BURST   (MAX_BURST),
    .BOUND_BEATS (BOUND_BEATS)
  ) u_calc (
    .i_remaining (r_remaining),
    .i_beat_idx  (r_addr[BOUND_SHIFT-1:BEAT_SHIFT]),
    .o_beats     (w_beats)
  );

  assign w_addr_hs  = (r_state == ST_ADDR) && bus.axi_aready;
  // Completion at zero is spurious and ignored so the counter cannot underflow.
  assign w_done_eff = bus.axi_done && (r_outstanding != '0);
  // A completion in the same cycle frees a slot immediately.
  assign w_credit   = (r_outstanding < OUT_W'(MAX_OUTSTANDING)) || w_done_eff;
  assign w_last     = (r_remaining == r_beats);

  always_comb begin
    w_next    = r_state;
    w_cfg_rdy = 1'b0;
    w_avalid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_rdy = 1'b1;
        if (bus.cfg_val && (w_total != '0)) w_next = ST_CALC;
      end
      ST_CALC: begin
        if (w_credit) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        w_avalid = 1'b1;
        if (bus.axi_aready) w_next = w_last ? ST_IDLE : ST_CALC;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_beats       <= '0;
      r_aaddr       <= '0;
      r_alen        <= '0;
      r_outstanding <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (bus.cfg_val) begin
            r_addr      <= w_cfg_addr;
            r_remaining <= w_total;
          end
        end
        ST_CALC: begin
          r_aaddr <= r_addr;
          r_alen  <= LW'(w_beats - REM_W'(1));
          r_beats <= w_beats;
        end
        ST_ADDR: begin
          if (bus.axi_aready) begin
            r_addr      <= r_addr + (AW'(r_beats) << BEAT_SHIFT);
            r_remaining <= r_remaining - r_beats;
          end
        end
        default: ;
      endcase
      if (w_addr_hs && !w_done_eff)
        r_outstanding <= r_outstanding + OUT_W'(1);
      else if (!w_addr_hs && w_done_eff)
        r_outstanding <= r_outstanding - OUT_W'(1);
    end
  end

  assign bus.cfg_rdy     = w_cfg_rdy;
  assign bus.axi_avalid  = w_avalid;
  assign bus.axi_aaddr   = r_aaddr;
  assign bus.axi_alen    = r_alen;
  assign bus.outstanding = r_outstanding;

endmodule

// File: tb/tb_axis_addr_split.sv
// Bench for axis_addr_split: directed cases plus randomized transfers, with an
// expected-burst queue filled from a reference model at config time and a
// negedge monitor that pops and compares on every address handshake.
module tb_axis_addr_split;

  localparam int unsigned CFG_DW = 32;
  localparam int unsigned RATIO  = 16;
  localparam int unsigned LW     = 8;
  localparam int unsigned AW     = 32;
  localparam int unsigned MB     = 16;
  localparam int unsigned BND    = 4096;
  localparam int unsigned MO     = 2;
  localparam longint      BB     = 64;   // 32 bits * 16 / 8

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } burst_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_addr_split_if #(
    .CFG_DWIDTH      (CFG_DW),
    .AXI_LEN_WIDTH   (LW),
    .AXI_ADDR_WIDTH  (AW),
    .MAX_OUTSTANDING (MO)
  ) bus ();

  axis_addr_split #(
    .CFG_DWIDTH      (CFG_DW),
    .WIDTH_RATIO     (RATIO),
    .AXI_LEN_WIDTH   (LW),
    .AXI_ADDR_WIDTH  (AW),
    .MAX_BURST       (MB),
    .BOUNDARY        (BND),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  burst_t      exp_q[$];
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          hs_cnt = 0;
  int          m_out  = 0;
  bit          pend   = 0;
  logic [31:0] pend_addr;
  logic [7:0]  pend_len;
  bit          rnd_ready = 0;
  bit          done_rnd  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the transfer in bursts using plain arithmetic.
  task automatic push_model(input logic [31:0] addr, input logic [31:0] len);
    longint a, rem, to_b, b;
    burst_t e;
    a   = longint'(addr) - (longint'(addr) % BB);
    rem = (longint'(len) + RATIO - 1) / RATIO;
    while (rem > 0) begin
      to_b = (BND - (a % BND)) / BB;
      b = rem;
      if (b > MB)   b = MB;
      if (b > to_b) b = to_b;
      e.addr = a[31:0];
      e.len  = 8'(b - 1);
      exp_q.push_back(e);
      a   = (a + b * BB) % 64'h1_0000_0000;
      rem = rem - b;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input logic [31:0] addr, input logic [31:0] len);
    for (int k = 0; k < 3000; k++) begin
      if (bus.cfg_rdy === 1'b1) break;
      step();
    end
    chk("cfg_rdy_wait", bus.cfg_rdy, 1);
    bus.cfg_address = addr;
    bus.cfg_length  = len;
    bus.cfg_val     = 1'b1;
    push_model(addr, len);
    step();
    bus.cfg_val = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus.cfg_rdy === 1'b1) break;
    end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_rdy", bus.cfg_rdy, 1);
    step();
  endtask

  task automatic wait_avalid(input string name);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.axi_avalid === 1'b1) break;
    end
    chk(name, bus.axi_avalid, 1);
    step();
  endtask

  task automatic flush_done();
    bus.axi_done = 1'b1;
    repeat (MO + 1) step();
    bus.axi_done = 1'b0;
    step();
  endtask

  // Monitor: outstanding model, hold checks, scoreboard pop on handshake.
  always @(negedge clk) begin
    burst_t e;
    int inc, dec;
    if (!rst) begin
      m_out = 0;
      exp_q.delete();
      pend = 0;
    end else begin
      chk("outstanding", bus.outstanding, m_out);
      if (pend) begin
        chk("avalid_hold", bus.axi_avalid, 1);
        chk("aaddr_hold", bus.axi_aaddr, pend_addr);
        chk("alen_hold", bus.axi_alen, pend_len);
      end
      pend = 0;
      if (bus.axi_avalid === 1'b1) begin
        if (bus.axi_aready === 1'b1) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_burst: got addr 0x%0h len %0d, expected no burst",
                     bus.axi_aaddr, bus.axi_alen);
          end else begin
            e = exp_q.pop_front();
            chk("burst_addr", bus.axi_aaddr, e.addr);
            chk("burst_len", bus.axi_alen, e.len);
          end
        end else begin
          pend      = 1;
          pend_addr = bus.axi_aaddr;
          pend_len  = bus.axi_alen;
        end
      end
      inc = (bus.axi_avalid === 1'b1 && bus.axi_aready === 1'b1) ? 1 : 0;
      dec = (bus.axi_done === 1'b1 && m_out > 0) ? 1 : 0;
      m_out = m_out + inc - dec;
    end
  end

  // Background randomizers, driven slightly after the stimulus slot.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) bus.axi_aready = ($urandom_range(0, 2) != 0);
      if (done_rnd)  bus.axi_done   = ($urandom_range(0, 3) == 0);
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    n_bad++;
    $display("FAIL watchdog: got no end of test, expected finish within 60000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int hs0;
    logic [31:0] a, l;
    bus.cfg_address = '0;
    bus.cfg_length  = '0;
    bus.cfg_val     = 1'b0;
    bus.axi_aready  = 1'b0;
    bus.axi_done    = 1'b0;

    // Reset values
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("rst_cfg_rdy", bus.cfg_rdy, 1);
    chk("rst_avalid", bus.axi_avalid, 0);
    chk("rst_aaddr", bus.axi_aaddr, 0);
    chk("rst_alen", bus.axi_alen, 0);
    chk("rst_outstanding", bus.outstanding, 0);
    step();
    rst = 1'b1;
    step();

    // Directed transfers: alignment, boundary split, MAX_BURST split
    bus.axi_aready = 1'b1;
    done_rnd = 1;
    send_cfg(32'd255, 32'd576);
    send_cfg(32'd4032, 32'd160);
    send_cfg(32'd0, 32'd640);
    send_cfg(32'h40, 32'd17);
    wait_drain();

    // Zero length: no burst, stays ready
    hs0 = hs_cnt;
    send_cfg(32'h100, 32'd0);
    repeat (4) begin
      @(negedge clk);
      chk("len0_avalid", bus.axi_avalid, 0);
      chk("len0_cfg_rdy", bus.cfg_rdy, 1);
    end
    chk("len0_no_burst", hs_cnt - hs0, 0);
    step();

    // Credit limit
    done_rnd = 0;
    bus.axi_done = 1'b0;
    flush_done();
    bus.axi_aready = 1'b1;
    hs0 = hs_cnt;
    send_cfg(32'd0, 32'd640);
    repeat (12) step();
    @(negedge clk);
    chk("credit_two_hs", hs_cnt - hs0, 2);
    chk("credit_full", bus.outstanding, 2);
    chk("credit_avalid_low", bus.axi_avalid, 0);
    step();
    bus.axi_aready = 1'b0;
    bus.axi_done   = 1'b1;
    step();
    bus.axi_done   = 1'b0;
    wait_avalid("credit_release");
    bus.axi_aready = 1'b1;
    bus.axi_done   = 1'b1;
    step();
    bus.axi_aready = 1'b0;
    bus.axi_done   = 1'b0;
    @(negedge clk);
    chk("done_with_hs", bus.outstanding, 1);
    chk("credit_three_hs", hs_cnt - hs0, 3);
    chk("credit_cfg_rdy", bus.cfg_rdy, 1);
    step();

    // Hold under backpressure, aready 1,0,1
    flush_done();
    send_cfg(32'd4032, 32'd160);
    wait_avalid("hold_avalid");
    repeat (3) step();
    bus.axi_aready = 1'b1;
    step();
    bus.axi_aready = 1'b0;
    step();
    bus.axi_aready = 1'b1;
    wait_drain();

    // Reset while in ADDR
    flush_done();
    bus.axi_aready = 1'b1;
    send_cfg(32'd0, 32'd640);
    repeat (12) step();
    bus.axi_aready = 1'b0;
    bus.axi_done   = 1'b1;
    step();
    bus.axi_done   = 1'b0;
    wait_avalid("pre_reset_avalid");
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_avalid", bus.axi_avalid, 0);
    chk("midrst_cfg_rdy", bus.cfg_rdy, 1);
    chk("midrst_outstanding", bus.outstanding, 0);
    step();
    bus.axi_aready = 1'b1;
    done_rnd = 1;
    send_cfg(32'h1000, 32'd100);
    wait_drain();

    // Randomized transfers
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       a = $urandom;
        1:       a = ($urandom & 32'hFFFF_F000) | 32'hF00 | ($urandom & 32'hFF);
        default: a = 32'hFFFF_FE00 | ($urandom & 32'h1FF);
      endcase
      l = $urandom_range(0, 400);
      send_cfg(a, l);
    end
    wait_drain();
    rnd_ready = 0;

    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_addr_split.md
Name: axis_addr_split

Overview:
Successor address generator for the AXI-stream DMA path. Converts one {byte address, length in CFG_DWIDTH words} config transfer into a sequence of AXI read/write address-channel bursts. Generalises the previous generator with a parametrised max burst length, 4 KB (parametrised) boundary splitting and an outstanding-transaction credit limit fed by a completion pulse. Sits between the config register bank and an AXI master's AR or AW channel.

Parameters:
CFG_DWIDTH, 32, config/stream word width in bits
WIDTH_RATIO, 16, AXI data width / CFG_DWIDTH (power of 2)
CONVERT_SHIFT, $clog2(WIDTH_RATIO), word-to-beat shift
AXI_LEN_WIDTH, 8, width of axi_alen
AXI_ADDR_WIDTH, 32, AXI address width
MAX_BURST, 256, max beats per burst (power of 2, <= 2^AXI_LEN_WIDTH)
BOUNDARY, 4096, bytes; no burst may cross a multiple of this (power of 2)
MAX_OUTSTANDING, 4, max issued bursts without a completion

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
cfg_address  in  CFG_DWIDTH  start byte address
cfg_length  in  CFG_DWIDTH  transfer length in CFG_DWIDTH words
cfg_val  in  1  config valid
cfg_rdy  out  1  config ready (idle)
axi_aready  in  1  AXI address ready
axi_aaddr  out  AXI_ADDR_WIDTH  burst start address
axi_alen  out  AXI_LEN_WIDTH  beats-1
axi_avalid  out  1  address valid
axi_done  in  1  one-cycle pulse per completed burst (B or last R)
outstanding  out  $clog2(MAX_OUTSTANDING+1)  bursts issued, not yet completed

Behaviour:
- Reset (rst low at posedge): state IDLE, cfg_rdy=1, axi_avalid=0, axi_aaddr=0, axi_alen=0, outstanding=0, internal counters 0. Reset mid-burst aborts immediately; avalid drops the next cycle.
- BEAT_BYTES = CFG_DWIDTH*WIDTH_RATIO/8. Captured address aligned down to BEAT_BYTES. Total beats = ceil(cfg_length / WIDTH_RATIO) = (cfg_length + WIDTH_RATIO-1) >> CONVERT_SHIFT; remaining-beats counter is CFG_DWIDTH-CONVERT_SHIFT+1 bits (no overflow at max length).
- Per burst: beats = min(remaining, MAX_BURST, (BOUNDARY - (addr mod BOUNDARY)) / BEAT_BYTES); axi_alen = beats-1; after handshake addr += beats*BEAT_BYTES (mod 2^AXI_ADDR_WIDTH), remaining -= beats.
- States:
  IDLE: cfg_rdy=1. cfg_val=1 -> capture, go CALC; if computed beats==0 (length 0) stay IDLE, no burst, cfg_rdy stays 1.
  CALC: cfg_rdy=0, avalid=0; registers burst addr/len (1 cycle). Go ADDR when credit is available (outstanding < MAX_OUTSTANDING, counting a same-cycle axi_done); otherwise wait in CALC.
  ADDR: avalid=1, aaddr/alen stable until axi_aready=1. On handshake: remaining==0 -> IDLE, else CALC. avalid never deasserts before handshake.
- Latency: cfg handshake -> avalid high 2 cycles later (with credit). Back-to-back bursts are separated by one CALC cycle.
- outstanding: +1 on address handshake, -1 on axi_done, unchanged if both same cycle; axi_done at 0 ignored (saturates). Counter persists across config transfers; cfg_rdy does not wait for outstanding to drain.
- cfg_val while not IDLE is ignored.

Decomposition:
- Package axis_addr_pkg: state encoding (IDLE, CALC, ADDR), derived constants BEAT_BYTES, BEAT_SHIFT, BOUND_BEATS, counter widths.
- Sub-module axis_addr_burst_calc: combinational min(remaining, MAX_BURST, beats-to-boundary); top holds FSM, counters and registers.

Test Plan:
- Defaults, cfg_address=255, cfg_length=576, aready=1 -> one burst aaddr=192, alen=35; cfg_rdy back high after handshake.
- cfg_address=4032, cfg_length=160 -> bursts (4032, alen 0) then (4096, alen 8); neither crosses 4096.
- MAX_BURST=16, cfg_address=0, cfg_length=640 -> bursts (0,15),(1024,15),(2048,7); length 17 -> single burst alen=1; length 0 -> no avalid, cfg_rdy stays 1.
- MAX_OUTSTANDING=2, 3-burst transfer, aready=1, no axi_done -> two handshakes, outstanding=2, avalid held low in CALC; one axi_done pulse -> third burst issues; axi_done coincident with handshake leaves count unchanged.
- aready toggling 1,0,1 while avalid high -> aaddr/alen stable, avalid held until accepted.
- rst low while in ADDR -> next cycle avalid=0, cfg_rdy=1, outstanding=0; new config then runs normally.
